uart_tx_fifo: RTL
=================

// Module: uart_tx_fifo
// PURPOSE
//   Byte buffer directly upstream of uart_tx. Accepts bursts of words from the
//   host/link logic and presents them one at a time over a valid/ready handshake
//   to the transmitter, which pops one word per serial frame. First-word-fall-
//   through; reports level, full/empty and a sticky overflow flag.
// PARAMETERS
//   DATA_WIDTH  8   width of each buffered word (matches uart_tx DATA_WIDTH)
//   DEPTH       16  number of entries; power of two, >= 2
//   LB_DEPTH    $clog2(DEPTH)  localparam, pointer width
// PORTS
//   clk       in   1              system clock
//   reset     in   1              synchronous, active-high reset
//   ena       in   1              block enable; low = freeze all state
//   wr_data   in   DATA_WIDTH     word to enqueue
//   wr_en     in   1              enqueue request, one word per cycle
//   full      out  1              level == DEPTH
//   empty     out  1              level == 0
//   level     out  LB_DEPTH+1     current number of stored words
//   overflow  out  1              sticky: a write was dropped because full
//   clr_ovf   in   1              clears overflow
//   tx_data   out  DATA_WIDTH     head word toward uart_tx
//   tx_valid  out  1              head word present (== !empty)
//   tx_ready  in   1              uart_tx accepts head word this cycle
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high. All state changes
//     on rising clk only.
//   - Reset: wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, tx_valid=0,
//     tx_data=0, overflow=0. Storage contents not cleared. Reset wins over
//     ena and all other inputs; reset mid-burst discards all stored words.
//   - Push: ena & wr_en & (!full | pop) -> mem[wr_ptr]<=wr_data, wr_ptr++.
//   - Pop: ena & tx_valid & tx_ready -> rd_ptr++.
//   - level: +1 on push only, -1 on pop only, unchanged on both/neither.
//   - Pointers LB_DEPTH bits, wrap DEPTH-1 -> 0 naturally; full/empty derived
//     from level, never from pointer compare alone.
//   - Latency: word written into empty FIFO at edge N appears on tx_data with
//     tx_valid=1 from edge N (visible cycle after the write). No pass-through.
//   - FWFT: tx_data = mem[rd_ptr] whenever tx_valid=1; tx_data forced 0 when
//     tx_valid=0. tx_data stable while tx_valid=1 and no pop.
//   - Simultaneous push+pop when full: both accepted, level stays DEPTH,
//     overflow not set. Push+pop when empty: pop impossible, push accepted.
//   - Overflow: ena & wr_en & full & !pop -> word dropped, overflow<=1.
//     clr_ovf clears overflow; same-cycle set and clear -> set wins.
//     clr_ovf honoured only when ena=1.
//   - ena=0: no push, no pop, no overflow set, outputs hold; wr_en/tx_ready
//     ignored. tx_valid/tx_data remain driven from held state.
//   - Words leave in exact write order; no duplication, no loss except the
//     overflow-drop case.
// TESTING
//   1. reset, write 0xA5 once, tx_ready=0 -> next cycle tx_valid=1,
//      tx_data=0xA5, level=1; hold 10 cycles -> unchanged.
//   2. write 0x00..0x0F back-to-back (DEPTH=16), then tx_ready=1 -> full=1
//      after 16th write; pops return 0x00..0x0F in order, empty=1 at end.
//   3. full FIFO, wr_en with 0x77 and tx_ready=0 -> word dropped, overflow=1,
//      level=16; assert clr_ovf -> overflow=0 next cycle.
//   4. full FIFO, wr_en=1 and tx_ready=1 same cycle -> level stays 16,
//      overflow=0, 0x77 emerges last; 40 random push/pop ops across pointer
//      wrap -> scoreboard order match.
//   5. ena=0 with wr_en=1, tx_ready=1 for 5 cycles -> level, pointers,
//      tx_data unchanged; ena=1 -> operation resumes.
//   6. level=5, assert reset for 1 cycle -> level=0, empty=1, tx_valid=0,
//      tx_data=0, overflow=0 next cycle.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - first-word-fall-through byte buffer feeding uart_tx
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ena,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_en,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow,
  input  logic                          clr_ovf,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready
);

  localparam int LB_DEPTH = $clog2(DEPTH);
  localparam logic [LB_DEPTH:0] FULL_LEVEL = (LB_DEPTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LB_DEPTH-1:0]   wr_ptr;
  logic [LB_DEPTH-1:0]   rd_ptr;
  logic [LB_DEPTH:0]     count;
  logic                  ovf_q;
  logic                  pop;
  logic                  push;
  logic                  drop;

  assign full     = (count == FULL_LEVEL);
  assign empty    = (count == '0);
  assign level    = count;
  assign overflow = ovf_q;
  assign tx_valid = !empty;

  // A pop frees the head slot in the same cycle, so a full FIFO still takes a write.
  assign pop  = ena && tx_valid && tx_ready;
  assign push = ena && wr_en && (!full || pop);
  assign drop = ena && wr_en && full && !pop;

  assign tx_data = tx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + LB_DEPTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LB_DEPTH'(1);
      end
      if (push && !pop) begin
        count <= count + (LB_DEPTH + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (LB_DEPTH + 1)'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ena && clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule
